// File: rtl/bool_tt_sweeper.sv
// bool_tt_sweeper: drives all 16 ABCD vectors into a boolean cell, captures its truth table and counts mismatches
module bool_tt_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        out,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam state_t     FIRST    = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d, cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d, sig_q, sig_d;
    logic [4:0]  mm_q, mm_d;
    logic        pass_q, pass_d;
    logic        hit, miss;
    // only a clean 1 is captured as 1; X or Z captures 0 and always counts as a miss
    always_comb begin
        hit  = (out === 1'b1);
        miss = (out !== exp_q[idx_q]);
    end
    // sweep sequencing: vector stepping, settle timing, capture and scoring
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (start) begin
                exp_d   = expected;
                idx_d   = 4'd0;
                cnt_d   = 4'd0;
                sig_d   = 16'd0;
                mm_d    = 5'd0;
                pass_d  = 1'b0;
                state_d = FIRST;
            end
            SETTLE: begin
                cnt_d   = (cnt_q == LAST_CNT) ? 4'd0 : cnt_q + 4'd1;
                state_d = (cnt_q == LAST_CNT) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                sig_d[idx_q] = hit;
                mm_d         = (miss && mm_q != 5'd16) ? mm_q + 5'd1 : mm_q;
                pass_d       = (idx_q == 4'd15) ? (mm_d == 5'd0) : pass_q;
                idx_d        = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
                state_d      = (idx_q == 4'd15) ? DONE : FIRST;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 16'd0;
            sig_q   <= 16'd0;
            mm_q    <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end
    assign {A, B, C, D}  = idx_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign sig           = sig_q;
    assign mismatch_cnt  = mm_q;
    assign pass          = pass_q;
endmodule

// File: tb/tb_bool_tt_sweeper.sv
// tb_bool_tt_sweeper: directed sweeps with a scoreboard of predicted truth-table results
module tb_bool_tt_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] exp0 = 16'd0, exp1 = 16'd0;
    logic [1:0]  mode = 2'd0;
    logic        a0, b0, c0, d0, busy0, done0, pass0;
    logic        a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] sig0, sig1;
    logic [4:0]  mm0, mm1;
    logic        model0, out1;
    wire         out0;

    // cell models: mode 0 -> A&B, mode 1 -> constant 0, mode 2 -> floating output
    always_comb model0 = (mode == 2'd0) ? (a0 & b0) : 1'b0;
    assign out0 = (mode == 2'd2) ? 1'bz : model0;
    always_comb out1 = ~d1;

    bool_tt_sweeper dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0), .out(out0),
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
        .sig(sig0), .mismatch_cnt(mm0), .pass(pass0)
    );
    bool_tt_sweeper #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1), .out(out1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
        .sig(sig1), .mismatch_cnt(mm1), .pass(pass1)
    );

    typedef struct {
        logic [15:0] sig;
        logic [4:0]  mm;
        logic        pass;
        int          lat;
    } res_t;
    res_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // mode 3 is the ~D cell of the zero-settle instance
    function automatic res_t predict(input logic [15:0] e, input logic [1:0] m, input int lat);
        res_t r;
        logic v;
        logic [3:0] x;
        r.sig = 16'd0;
        r.mm  = 5'd0;
        r.lat = lat;
        for (int i = 0; i < 16; i++) begin
            x = 4'(i);
            v = (m == 2'd2) ? out0 : (m == 2'd0) ? (x[3] & x[2]) : (m == 2'd3) ? ~x[0] : 1'b0;
            r.sig[i] = (v === 1'b1);
            if (v !== e[i] && r.mm != 5'd16) r.mm = r.mm + 5'd1;
        end
        r.pass = (r.mm == 5'd0);
        return r;
    endfunction

    task automatic launch0(input logic [15:0] e, input logic [1:0] m, input bit push);
        @(negedge clk);
        mode = m;
        exp0 = e;
        start0 = 1'b1;
        #1;
        if (push) sb.push_back(predict(e, m, 48));
        @(negedge clk);
        start0 = 1'b0;
        acc = cyc;
        check("accept_busy", busy0, 1);
        check("accept_abcd", {a0, b0, c0, d0}, 0);
    endtask

    task automatic wait_done(input bit which, input string tag);
        res_t r;
        int n;
        n = 0;
        while (!(which ? done1 : done0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, which ? done1 : done0, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            r = sb.pop_front();
            check({tag, "_lat"}, cyc - acc, r.lat);
            check({tag, "_sig"}, which ? sig1 : sig0, r.sig);
            check({tag, "_mm"}, which ? mm1 : mm0, r.mm);
            check({tag, "_pass"}, which ? pass1 : pass0, r.pass);
        end
    endtask

    task automatic wait_abcd0(input logic [3:0] v);
        int n;
        n = 0;
        while ({a0, b0, c0, d0} != v && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abcd_reach", {a0, b0, c0, d0}, v);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_abcd"}, {a0, b0, c0, d0}, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_sig"}, sig0, 0);
        check({tag, "_mm"}, mm0, 0);
        check({tag, "_pass"}, pass0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset0("por");
        check("por1_busy", busy1, 0);
        // reset in the middle of a sweep at vector 7
        launch0(16'hF000, 2'd0, 1'b0);
        wait_abcd0(4'd7);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", done0, 0);
        end
        rst = 1'b0;
        check_reset0("midrst");
        repeat (3) @(negedge clk);
        check("after_rst_done", done0, 0);
        // A&B cell, correct table
        launch0(16'hF000, 2'd0, 1'b1);
        wait_done(1'b0, "and_ok");
        @(negedge clk);
        check("post_done_busy", busy0, 0);
        check("post_done_pulse", done0, 0);
        check("hold_abcd", {a0, b0, c0, d0}, 4'hF);
        check("hold_sig", sig0, 16'hF000);
        // A&B cell, one wrong entry
        launch0(16'hF001, 2'd0, 1'b1);
        wait_done(1'b0, "and_bad");
        // floating output
        launch0(16'h0000, 2'd2, 1'b1);
        wait_done(1'b0, "float");
        // every vector wrong: counter must stop at 16
        launch0(16'hFFFF, 2'd1, 1'b1);
        wait_done(1'b0, "sat");
        repeat (4) @(negedge clk);
        check("sat_hold_mm", mm0, 16);
        // zero-settle instance with ~D cell
        @(negedge clk);
        exp1 = 16'h5555;
        start1 = 1'b1;
        sb.push_back(predict(16'h5555, 2'd3, 16));
        @(negedge clk);
        start1 = 1'b0;
        acc = cyc;
        for (int k = 0; k < 16; k++) begin
            check("step_abcd", {a1, b1, c1, d1}, k);
            check("step_no_done", done1, 0);
            @(negedge clk);
        end
        wait_done(1'b1, "nd");
        // ignored start and expected changes mid-sweep
        launch0(16'hF000, 2'd0, 1'b1);
        wait_abcd0(4'd5);
        start0 = 1'b1;
        exp0 = 16'h0000;
        @(negedge clk);
        start0 = 1'b0;
        check("norestart_abcd", {a0, b0, c0, d0}, 5);
        check("norestart_busy", busy0, 1);
        repeat (5) @(negedge clk);
        exp0 = 16'hFFFF;
        wait_done(1'b0, "ignore");
        // start held high: exactly one idle cycle then a new sweep
        exp0 = 16'hF000;
        start0 = 1'b1;
        sb.push_back(predict(16'hF000, 2'd0, 48));
        @(negedge clk);
        check("b2b_idle", busy0, 0);
        @(negedge clk);
        acc = cyc;
        check("b2b_busy", busy0, 1);
        check("b2b_abcd", {a0, b0, c0, d0}, 0);
        start0 = 1'b0;
        wait_done(1'b0, "b2b");
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
